// File: rtl/hack_pkg.sv
// Shared definitions for the Hack multiply sequencer: state encoding and the
// six-bit ALU control words in {zx,nx,zy,ny,f,no} order.
package hack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [5:0] ALU_ADD  = 6'b000010;
  localparam logic [5:0] ALU_ZERO = 6'b101010;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  function automatic alu_ctrl_t alu_ctrl(input logic [5:0] code);
    return alu_ctrl_t'(code);
  endfunction

endpackage

// File: rtl/hack_alu.sv
// Standard 16-bit Hack ALU: purely combinational, x/y preset, negate,
// add-or-and, and output negate, plus zero/negative flags.
module hack_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x_z;
  logic [15:0] x_n;
  logic [15:0] y_z;
  logic [15:0] y_n;
  logic [15:0] fn;

  always_comb begin
    x_z = zx ? 16'h0000 : x;
    x_n = nx ? ~x_z : x_z;
    y_z = zy ? 16'h0000 : y;
    y_n = ny ? ~y_z : y_z;
    fn  = f ? (x_n + y_n) : (x_n & y_n);
    out = no ? ~fn : fn;
    zr  = (out == 16'h0000);
    ng  = out[15];
  end

endmodule

// File: rtl/hack_mul_unit.sv
// Standalone multiply unit: the sequencer paired with its own Hack ALU.
module hack_mul_unit (
`ifdef USE_POWER_PINS
  inout  wire         vccd1,
  inout  wire         vssd1,
`endif
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] prod,
  output logic        alu_zr,
  output logic        alu_ng
);

  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [15:0] alu_out;
  logic        alu_zx;
  logic        alu_nx;
  logic        alu_zy;
  logic        alu_ny;
  logic        alu_f;
  logic        alu_no;

  hack_mul_seq #(.WIDTH(16)) u_seq (
`ifdef USE_POWER_PINS
    .vccd1      (vccd1),
    .vssd1      (vssd1),
`endif
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .a          (a),
    .b          (b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .prod       (prod),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_zx     (alu_zx),
    .alu_nx     (alu_nx),
    .alu_zy     (alu_zy),
    .alu_ny     (alu_ny),
    .alu_f      (alu_f),
    .alu_no     (alu_no),
    .alu_out    (alu_out)
  );

  hack_alu u_alu (
    .x   (alu_x),
    .y   (alu_y),
    .zx  (alu_zx),
    .nx  (alu_nx),
    .zy  (alu_zy),
    .ny  (alu_ny),
    .f   (alu_f),
    .no  (alu_no),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

endmodule

// File: rtl/hack_mul_seq.sv
// Shift-and-add multiplier that borrows an external Hack ALU for every add;
// it keeps only the accumulator, shifted multiplicand and remaining multiplier.
module hack_mul_seq #(
  parameter int WIDTH = 16
) (
`ifdef USE_POWER_PINS
  inout  wire              vccd1,
  inout  wire              vssd1,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] prod,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out
);

  import hack_pkg::*;

  state_e           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic [WIDTH-1:0] mp_shr;
  logic [5:0]       alu_code;
  alu_ctrl_t        ctrl;

  assign mp_shr = mp >> 1;

  // Sequencer: ADD folds the current multiplicand into acc, DBL doubles it
  // through the ALU (mc + mc) while the multiplier shifts right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      mc    <= '0;
      mp    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            acc <= '0;
            mc  <= a;
            mp  <= b;
            if (b == '0)     state <= DONE;
            else if (b[0])   state <= ADD;
            else             state <= DBL;
          end
        end
        ADD: begin
          acc   <= alu_out;
          state <= (mp_shr == '0) ? DONE : DBL;
        end
        DBL: begin
          mc    <= alu_out;
          mp    <= mp_shr;
          state <= mp_shr[0] ? ADD : DBL;
        end
        DONE: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU drive is a pure decode of registered state, so the combinational
  // ALU path never sees the handshake inputs.
  always_comb begin
    alu_code = ALU_ZERO;
    alu_x    = '0;
    alu_y    = '0;
    case (state)
      ADD: begin
        alu_code = ALU_ADD;
        alu_x    = acc;
        alu_y    = mc;
      end
      DBL: begin
        alu_code = ALU_ADD;
        alu_x    = mc;
        alu_y    = mc;
      end
      default: ;
    endcase
  end

  assign ctrl       = alu_ctrl(alu_code);
  assign alu_zx     = ctrl.zx;
  assign alu_nx     = ctrl.nx;
  assign alu_zy     = ctrl.zy;
  assign alu_ny     = ctrl.ny;
  assign alu_f      = ctrl.f;
  assign alu_no     = ctrl.no;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign prod       = acc;

endmodule

// File: tb/tb_hack_mul_seq.sv
// Bench for hack_mul_seq: directed cases plus random multiplies checked
// against a plain a*b / popcount latency model.
module tb_hack_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] prod;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [15:0] alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic        alu_zr, alu_ng;
  logic [5:0]  code;

  logic        u_req_ready;
  logic        u_resp_valid;
  logic [15:0] u_prod;
  logic        u_zr, u_ng;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [5:0] CODE_ADD  = 6'b000010;
  localparam logic [5:0] CODE_ZERO = 6'b101010;

  assign code = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};

  hack_mul_seq #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .a          (a),
    .b          (b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .prod       (prod),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_zx     (alu_zx),
    .alu_nx     (alu_nx),
    .alu_zy     (alu_zy),
    .alu_ny     (alu_ny),
    .alu_f      (alu_f),
    .alu_no     (alu_no),
    .alu_out    (alu_out)
  );

  hack_alu u_alu (
    .x   (alu_x),
    .y   (alu_y),
    .zx  (alu_zx),
    .nx  (alu_nx),
    .zy  (alu_zy),
    .ny  (alu_ny),
    .f   (alu_f),
    .no  (alu_no),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  hack_mul_unit u_unit (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (u_req_ready),
    .a          (a),
    .b          (b),
    .resp_valid (u_resp_valid),
    .resp_ready (resp_ready),
    .prod       (u_prod),
    .alu_zr     (u_zr),
    .alu_ng     (u_ng)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_prod(input logic [15:0] ma, input logic [15:0] mb);
    logic [31:0] full;
    full = 32'(ma) * 32'(mb);
    return full[15:0];
  endfunction

  // Cycles from the accept edge until resp_valid is seen.
  function automatic int model_latency(input logic [15:0] mb);
    int k;
    if (mb == 16'h0000) return 1;
    k = 0;
    for (int i = 0; i < 16; i++) if (mb[i]) k = i;
    return $countones(mb) + k + 1;
  endfunction

  // Called just after a negedge; returns at the negedge where resp_valid is seen.
  task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb_v, input bit keep, input int gap);
    int waits;
    int cnt;
    logic [15:0] exp;
    exp = model_prod(ta, tb_v);
    a = ta;
    b = tb_v;
    req_valid = 1'b1;
    waits = 0;
    while (!req_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (gap >= 0) chk("idle_gap", 32'(waits), 32'(gap));
    @(posedge clk);
    #1;
    req_valid = keep ? 1'b1 : 1'($urandom_range(0, 1));
    a = 16'($urandom);
    b = 16'($urandom);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (!resp_valid) begin
        chk("busy_ready", 32'(req_ready), 32'(0));
        chk("busy_code", 32'(code), 32'(CODE_ADD));
      end
    end while (!resp_valid && cnt < 80);
    if (!keep) req_valid = 1'b0;
    chk("latency", 32'(cnt), 32'(model_latency(tb_v)));
    chk("prod", 32'(prod), 32'(exp));
    chk("unit_prod", 32'(u_prod), 32'(exp));
    chk("unit_valid", 32'(u_resp_valid), 32'(1));
    chk("done_code", 32'(code), 32'(CODE_ZERO));
    chk("done_xy", {alu_x, alu_y}, 32'(0));
  endtask

  task automatic after_resp();
    @(negedge clk);
    chk("resp_one_cycle", 32'(resp_valid), 32'(0));
    chk("back_idle", 32'(req_ready), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    a          = 16'h0000;
    b          = 16'h0000;
    #1;
    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_valid", 32'(resp_valid), 32'(0));
    chk("rst_prod", 32'(prod), 32'(0));
    chk("rst_code", 32'(code), 32'(CODE_ZERO));
    chk("rst_xy", {alu_x, alu_y}, 32'(0));
    chk("rst_alu_flags", {30'(alu_out), alu_zr, alu_ng}, 32'b10);
    chk("rst_unit", {29'(u_prod), u_req_ready, u_zr, u_ng}, 32'b110);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(16'd3, 16'd5, 1'b0, -1);
    after_resp();
    run_txn(16'h1234, 16'h0000, 1'b0, -1);
    after_resp();
    run_txn(16'hFFFD, 16'h0007, 1'b0, -1);
    after_resp();
    run_txn(16'h0100, 16'h0100, 1'b0, -1);
    after_resp();
    run_txn(16'h0000, 16'hA5A5, 1'b0, -1);
    after_resp();

    // Backpressure with a competing request that must be ignored.
    resp_ready = 1'b0;
    run_txn(16'h0002, 16'hFFFF, 1'b0, -1);
    req_valid = 1'b1;
    a = 16'h0009;
    b = 16'h0003;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'(1));
      chk("bp_prod", 32'(prod), 32'hFFFE);
      chk("bp_ready", 32'(req_ready), 32'(0));
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(resp_valid), 32'(0));
    chk("bp_idle", 32'(req_ready), 32'(1));
    chk("bp_prod_hold", 32'(prod), 32'hFFFE);

    // Back-to-back with req_valid held high.
    run_txn(16'h0011, 16'h0013, 1'b1, -1);
    run_txn(16'hBEEF, 16'h0000, 1'b1, 1);
    run_txn(16'h7FFF, 16'h8001, 1'b1, 1);
    run_txn(16'hFFFF, 16'hFFFF, 1'b1, 1);
    req_valid = 1'b0;
    after_resp();

    // Reset in the eighth doubling cycle of a long request.
    a = 16'd5;
    b = 16'h8000;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_code", 32'(code), 32'(CODE_ADD));
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(req_ready), 32'(1));
    chk("arst_valid", 32'(resp_valid), 32'(0));
    chk("arst_prod", 32'(prod), 32'(0));
    chk("arst_code", 32'(code), 32'(CODE_ZERO));
    chk("arst_xy", {alu_x, alu_y}, 32'(0));
    repeat (3) begin
      @(negedge clk);
      chk("arst_hold_valid", 32'(resp_valid), 32'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_no_resp", 32'(resp_valid), 32'(0));
    run_txn(16'd6, 16'd7, 1'b0, -1);
    after_resp();

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 3 == 1) rb = rb & 16'($urandom);
      if (i % 5 == 2) rb = rb >> $urandom_range(0, 15);
      run_txn(ra, rb, 1'b0, -1);
      after_resp();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
